// File: rtl/ram_port_arbiter.sv
// Three-way arbiter in front of the single-port parameter/image RAM, with locked bursts.
// Define ARB_ROUND_ROBIN_EN to swap the fixed 0>1>2 base policy for round-robin.
module ram_port_arbiter #(
   parameter int AW        = 16,
   parameter int DW        = 8,
   parameter int READ_LAT  = 1,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              RST,
   input  logic [2:0]        req,
   input  logic [2:0]        lock,
   input  logic [2:0]        we,
   input  logic [3*AW-1:0]   addr,
   input  logic [3*DW-1:0]   wdata,
   output logic [2:0]        ack,
   output logic [DW-1:0]     rdata,
   output logic [1:0]        grant_id,
   output logic              busy,
   output logic [AW-1:0]     ramAddress,
   output logic [DW-1:0]     ramDataIn,
   input  logic [DW-1:0]     ramDataOut,
   output logic              readSignal,
   output logic              writeSignal
);

   localparam int BCW = $clog2(MAX_BURST) + 1;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT_RD, ACK} stateT;

   stateT           state;
   logic            weLatched;
   logic [BCW-1:0]  burstCnt;
   logic [2:0]      waitCnt;
   logic [AW-1:0]   addrArr  [3];
   logic [DW-1:0]   wdataArr [3];
   logic [3:0]      reqPad;
   logic [3:0]      lockPad;
   logic            burstHit;
   logic [1:0]      basePick;
   logic [1:0]      pick;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : gUnpack
         assign addrArr[gi]  = addr[gi*AW +: AW];
         assign wdataArr[gi] = wdata[gi*DW +: DW];
      end
   endgenerate

   // Padded so grant_id==3 (no winner yet) indexes a constant zero.
   assign reqPad  = {1'b0, req};
   assign lockPad = {1'b0, lock};

`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0] rrPtr;

   function automatic logic [1:0] rrIdx(input logic [1:0] p, input int k);
      int s;
      s = (int'(p) + 1 + k) % 3;
      return s[1:0];
   endfunction
`endif

   always_comb begin
      basePick = 2'd2;
      burstHit = (grant_id != 2'd3) && reqPad[grant_id] && lockPad[grant_id]
                 && (int'(burstCnt) < MAX_BURST - 1);
`ifdef ARB_ROUND_ROBIN_EN
      // Walk backwards so the nearest candidate after rrPtr overwrites the rest.
      for (int k = 2; k >= 0; k--) begin
         if (reqPad[rrIdx(rrPtr, k)]) basePick = rrIdx(rrPtr, k);
      end
`else
      if (req[0])      basePick = 2'd0;
      else if (req[1]) basePick = 2'd1;
      else             basePick = 2'd2;
`endif
      pick = burstHit ? grant_id : basePick;
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         ack         <= '0;
         rdata       <= '0;
         grant_id    <= 2'd3;
         busy        <= 1'b0;
         ramAddress  <= '0;
         ramDataIn   <= '0;
         readSignal  <= 1'b0;
         writeSignal <= 1'b0;
         weLatched   <= 1'b0;
         burstCnt    <= '0;
         waitCnt     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         rrPtr       <= 2'd0;
`endif
      end else begin
         ack         <= '0;
         readSignal  <= 1'b0;
         writeSignal <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  grant_id    <= pick;
                  ramAddress  <= addrArr[pick];
                  ramDataIn   <= wdataArr[pick];
                  weLatched   <= we[pick];
                  writeSignal <= we[pick];
                  readSignal  <= ~we[pick];
                  busy        <= 1'b1;
                  state       <= ACCESS;
                  if (burstHit) begin
                     burstCnt <= burstCnt + 1'b1;
                  end else begin
                     burstCnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                     rrPtr    <= pick;
`endif
                  end
               end
            end
            ACCESS: begin
               if (weLatched || READ_LAT == 1) begin
                  if (!weLatched) rdata <= ramDataOut;
                  ack   <= 3'b001 << grant_id;
                  state <= ACK;
               end else begin
                  waitCnt <= 3'(READ_LAT - 1);
                  state   <= WAIT_RD;
               end
            end
            WAIT_RD: begin
               // Leaving on the edge where the counter would reach zero.
               if (waitCnt <= 3'd1) begin
                  rdata   <= ramDataOut;
                  ack     <= 3'b001 << grant_id;
                  waitCnt <= '0;
                  state   <= ACK;
               end else begin
                  waitCnt <= waitCnt - 3'd1;
               end
            end
            ACK: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed requester traffic, behavioural RAM with READ_LAT=2.
module tb_ram_port_arbiter;

   localparam int AW = 16;
   localparam int DW = 8;
   localparam int RL = 2;

   typedef struct {
      int         id;
      logic       w;
      logic [15:0] a;
      logic [7:0] d;
      int         ackCyc;
   } expT;

   logic            clk = 1'b0;
   logic            RST;
   logic [2:0]      req, lock, we;
   logic [3*AW-1:0] addr;
   logic [3*DW-1:0] wdata;
   logic [2:0]      ack;
   logic [DW-1:0]   rdata;
   logic [1:0]      grant_id;
   logic            busy;
   logic [AW-1:0]   ramAddress;
   logic [DW-1:0]   ramDataIn;
   logic [DW-1:0]   ramDataOut;
   logic            readSignal, writeSignal;

   expT   expQ[$];
   expT   e;
   int    cyc = 0;
   int    nVec = 0;
   int    nFail = 0;
   int    rdAge = 0;
   int    lastWCyc = -100;
   int    lastRCyc = -100;
   logic [15:0] lastWAddr, lastRAddr;
   logic [7:0]  lastWData;
   logic [7:0]  mem [0:65535];

   ram_port_arbiter #(.AW(AW), .DW(DW), .READ_LAT(RL), .MAX_BURST(8)) dut (
      .clk(clk), .RST(RST), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .grant_id(grant_id), .busy(busy), .ramAddress(ramAddress),
      .ramDataIn(ramDataIn), .ramDataOut(ramDataOut), .readSignal(readSignal),
      .writeSignal(writeSignal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: data on ramDataOut only once READ_LAT has elapsed since the strobe.
   always @(posedge clk) begin
      if (!RST) mem[16'h0010] <= 8'h5A;
      else if (writeSignal) mem[ramAddress] <= ramDataIn;
   end
   always @(posedge clk) begin
      if (readSignal) rdAge <= 1;
      else if (rdAge != 0 && rdAge < 15) rdAge <= rdAge + 1;
   end
   assign ramDataOut = ((RL == 1 && readSignal) || (RL > 1 && rdAge == RL - 1))
                       ? mem[ramAddress] : 8'hEE;

   function automatic void chk(input string name, input longint act, input longint req_v);
      nVec++;
      if (act != req_v) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req_v, cyc);
      end
   endfunction

   task automatic pushExp(input int id, input logic w, input logic [15:0] a,
                          input logic [7:0] d, input int c);
      expT x;
      x.id = id; x.w = w; x.a = a; x.d = d; x.ackCyc = c;
      expQ.push_back(x);
   endtask

   // Caller is 1 time unit after a rising edge; returns in the cycle after the ack.
   task automatic access(input int id, input logic w, input logic [15:0] a,
                         input logic [7:0] d, input logic lk, input logic keep);
      int n;
      req[id] = 1'b1;
      lock[id] = lk;
      we[id] = w;
      addr[id*AW +: AW] = a;
      wdata[id*DW +: DW] = d;
      n = 0;
      @(negedge clk);
      while (!ack[id] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         nVec++;
         nFail++;
         $display("FAIL ack_timeout: requester %0d got no ack, expected one within 100 cycles", id);
      end
      @(posedge clk);
      #1;
      if (!keep) begin
         req[id] = 1'b0;
         lock[id] = 1'b0;
      end
   endtask

   // Monitor: strobe exclusivity every strobe cycle, full scoreboard compare on every ack.
   always @(negedge clk) begin
      if (RST) begin
         if (writeSignal || readSignal) chk("strobe_excl", {readSignal, writeSignal} == 2'b11, 0);
         if (writeSignal) begin
            lastWCyc = cyc; lastWAddr = ramAddress; lastWData = ramDataIn;
         end
         if (readSignal) begin
            lastRCyc = cyc; lastRAddr = ramAddress;
         end
         if (ack != 3'b000) begin
            if (expQ.size() == 0) begin
               chk("unexpected_ack", ack, 0);
            end else begin
               e = expQ.pop_front();
               chk("ack_onehot", ack, 3'b001 << e.id);
               chk("grant_id", grant_id, e.id);
               chk("busy_in_ack", busy, 1);
               if (e.ackCyc >= 0) chk("ack_cycle", cyc, e.ackCyc);
               if (e.w) begin
                  chk("wr_strobe_cycle", lastWCyc, cyc - 1);
                  chk("wr_addr", lastWAddr, e.a);
                  chk("wr_data", lastWData, e.d);
               end else begin
                  chk("rd_strobe_cycle", lastRCyc, cyc - RL);
                  chk("rd_addr", lastRAddr, e.a);
                  chk("rdata", rdata, e.d);
               end
               $display("ack: req %0d %s addr %04h data %02h at cycle %0d", e.id,
                        e.w ? "wr" : "rd", e.a, e.w ? e.d : rdata, cyc);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int t;
      req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
      RST = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack", ack, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_grant_id", grant_id, 3);
      chk("rst_busy", busy, 0);
      chk("rst_ramAddress", ramAddress, 0);
      chk("rst_ramDataIn", ramDataIn, 0);
      chk("rst_strobes", {readSignal, writeSignal}, 0);
      RST = 1'b1;
      @(posedge clk);
      #1;

      // Single write
      pushExp(0, 1'b1, 16'h0002, 8'h00, cyc + 2);
      access(0, 1'b1, 16'h0002, 8'h00, 1'b0, 1'b0);

      // Simultaneous writes from all three
      t = cyc;
`ifdef ARB_ROUND_ROBIN_EN
      pushExp(1, 1'b1, 16'h0021, 8'h22, t + 2);
      pushExp(2, 1'b1, 16'h0022, 8'h33, t + 5);
      pushExp(0, 1'b1, 16'h0020, 8'h11, t + 8);
`else
      pushExp(0, 1'b1, 16'h0020, 8'h11, t + 2);
      pushExp(1, 1'b1, 16'h0021, 8'h22, t + 5);
      pushExp(2, 1'b1, 16'h0022, 8'h33, t + 8);
`endif
      fork
         access(0, 1'b1, 16'h0020, 8'h11, 1'b0, 1'b0);
         access(1, 1'b1, 16'h0021, 8'h22, 1'b0, 1'b0);
         access(2, 1'b1, 16'h0022, 8'h33, 1'b0, 1'b0);
      join

      // Reads: preloaded location, then one written above
      pushExp(2, 1'b0, 16'h0010, 8'h5A, cyc + 1 + RL);
      access(2, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0);
      pushExp(1, 1'b0, 16'h0021, 8'h22, cyc + 1 + RL);
      access(1, 1'b0, 16'h0021, 8'h00, 1'b0, 1'b0);

      // Back-to-back writes from requester 0
      t = cyc;
      for (int i = 0; i < 4; i++) pushExp(0, 1'b1, 16'h0030 + 16'(i), 8'h40 + 8'(i), t + 2 + 3*i);
      for (int i = 0; i < 4; i++) access(0, 1'b1, 16'h0030 + 16'(i), 8'h40 + 8'(i), 1'b0, i < 3);

      // Locked burst by 1 with requester 0 waiting
      t = cyc;
      for (int i = 0; i < 8; i++) pushExp(1, 1'b1, 16'h0100 + 16'(i), 8'h10 + 8'(i), t + 2 + 3*i);
      pushExp(0, 1'b1, 16'h0200, 8'hA5, t + 26);
      pushExp(1, 1'b1, 16'h0108, 8'h18, t + 29);
      pushExp(1, 1'b1, 16'h0109, 8'h19, t + 32);
      fork
         begin
            for (int i = 0; i < 10; i++)
               access(1, 1'b1, 16'h0100 + 16'(i), 8'h10 + 8'(i), 1'b1, i < 9);
         end
         begin
            @(posedge clk);
            #1;
            access(0, 1'b1, 16'h0200, 8'hA5, 1'b0, 1'b0);
         end
      join

      pushExp(0, 1'b0, 16'h0105, 8'h15, cyc + 1 + RL);
      access(0, 1'b0, 16'h0105, 8'h00, 1'b0, 1'b0);

      // Reset while the read sits in WAIT_RD
      req[2] = 1'b1; we[2] = 1'b0; addr[2*AW +: AW] = 16'h0010;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("busy_wait_rd", busy, 1);
      chk("readSignal_wait_rd", readSignal, 0);
      RST = 1'b0;
      #1;
      req = '0;
      chk("midrst_ack", ack, 0);
      chk("midrst_rdata", rdata, 0);
      chk("midrst_grant_id", grant_id, 3);
      chk("midrst_busy", busy, 0);
      chk("midrst_ramAddress", ramAddress, 0);
      chk("midrst_strobes", {readSignal, writeSignal}, 0);
      @(posedge clk);
      #1;
      RST = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_no_ack", ack, 0);
      end

      repeat (3) @(posedge clk);
      chk("queue_empty", expQ.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
